zebra_frame_detector: RTL
=========================

ZEBRA_FRAME_DETECTOR -- requirements
Module: zebra_frame_detector

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 640: active pixels per line.
REQ-002 SHALL have parameter IMG_HEIGHT, default 480: active lines per frame.
REQ-003 SHALL have parameter W, default 8: edge-magnitude width.
REQ-004 SHALL have parameter ROI_Y0, default 240, and ROI_Y1, default 479: inclusive row band searched.
REQ-005 SHALL have parameters MIN_STRIPES, default 3, and MAX_STRIPES, default 12: per-row stripe window, inclusive.
REQ-006 SHALL have parameter ROW_QUORUM, default 32: qualifying rows needed for a frame hit.
REQ-007 SHALL have parameters ON_FRAMES, default 3, and OFF_FRAMES, default 5: hysteresis depths, each >= 1.
REQ-008 SHALL have ports: clk in 1, the single clock; rst in 1, synchronous active-high reset.
REQ-009 SHALL have ports: x_valid in 1, pixel strobe; x_data in W, edge magnitude; frame_start in 1, qualifies the current pixel as pixel (0,0); edge_thresh in W, binarisation threshold.
REQ-010 SHALL have ports: detection_valid out 1, end-of-frame pulse; frame_hit out 1; stripe_count out 8; confidence out 16; crossing_detected out 1, hysteresis-filtered result.

Function
REQ-011 SHALL keep column counter x and row counter y, advancing x only on x_valid, wrapping x at IMG_WIDTH-1 to 0 with y+1, and wrapping y at IMG_HEIGHT-1 to 0.
REQ-012 SHALL treat x_valid with frame_start as pixel (0,0), so counters go to (1,0) afterwards; if the previous frame was incomplete, SHALL discard it with no detection_valid.
REQ-013 SHALL binarise each accepted pixel as b = (x_data >= edge_thresh), unsigned.
REQ-014 SHALL count 0->1 transitions of b within each row in [ROI_Y0, ROI_Y1]; the bit before x=0 is 0; count saturates at 255.
REQ-015 SHALL evaluate the row on its last pixel, counting that pixel's transition; row qualifies if MIN_STRIPES <= count <= MAX_STRIPES.
REQ-016 SHALL track qualifying rows (16-bit, saturating at 65535) and the maximum count among qualifying rows per frame.
REQ-017 SHALL, on the cycle after the last pixel (x=IMG_WIDTH-1, y=IMG_HEIGHT-1) is accepted, pulse detection_valid for exactly one cycle and register confidence, stripe_count (0 if none qualified) and frame_hit = (confidence >= ROW_QUORUM); per-frame accumulators then clear.
REQ-018 SHALL hold frame_hit, stripe_count and confidence stable between detection_valid pulses.
REQ-019 SHALL run a hysteresis FSM advanced only on detection_valid, with states IDLE, ARMING, DETECTED, RELEASING.
REQ-020 IDLE: hit -> ARMING with hit_cnt=1 (straight to DETECTED if ON_FRAMES=1); miss -> stay.
REQ-021 ARMING: hit increments hit_cnt and enters DETECTED at ON_FRAMES; miss -> IDLE.
REQ-022 DETECTED: miss -> RELEASING with miss_cnt=1 (straight to IDLE if OFF_FRAMES=1); hit -> stay.
REQ-023 RELEASING: miss increments miss_cnt and enters IDLE at OFF_FRAMES; hit -> DETECTED.
REQ-024 crossing_detected SHALL be registered, high exactly in DETECTED and RELEASING, and change on the same edge as the state.
REQ-025 x_valid low SHALL freeze all counters and the FSM; the module applies no backpressure.

Reset
REQ-026 rst SHALL clear x, y, all accumulators, hit_cnt and miss_cnt, set the FSM to IDLE, and drive every output to 0 on the next edge, overriding x_valid and frame_start in the same cycle.
REQ-027 After rst, the first detection_valid SHALL follow only a complete frame.

Structure
REQ-028 Package zebra_pkg SHALL hold the FSM state enum, the default-parameter localparams and the count-width constants.
REQ-029 Per-row transition counting and qualification SHALL be sub-module row_stripe_counter; frame accumulation and the FSM stay in the top.

Verification
REQ-030 IMG 16x4, ROI rows 0-3, thresh 64, MIN=2, MAX=4, QUORUM=3: every row alternating 0/200 in 2-pixel runs (4 stripes) -> detection_valid one cycle after pixel 63, confidence=4, stripe_count=4, frame_hit=1.
REQ-031 Same parameters, rows carrying 1, 5, 4, 2 stripes -> confidence=2, stripe_count=4, frame_hit=0.
REQ-032 ON_FRAMES=3, OFF_FRAMES=2, frame pattern hit,hit,miss,hit,hit,hit,miss,hit,miss,miss -> crossing_detected rises after frame 6, stays high through frames 7-8, falls after frame 10.
REQ-033 frame_start asserted at pixel 20 of frame 1 -> no detection_valid for frame 1; the next pulse follows the 64th pixel counted from that frame_start.
REQ-034 x_valid gated 50% random -> results identical to the gap-free run; x_data=edge_thresh counts as 1, edge_thresh-1 as 0.
REQ-035 rst for 1 cycle in DETECTED mid-frame -> all outputs 0 next cycle; a full stripe frame then yields a pulse with IDLE->ARMING.

Source files
------------

// File: rtl/zebra_pkg.sv
// Shared types and constants for the zebra-crossing frame detector.
// Holds the hysteresis state encoding, default parameters and count widths.
package zebra_pkg;

    localparam int DEF_IMG_WIDTH   = 640;
    localparam int DEF_IMG_HEIGHT  = 480;
    localparam int DEF_W           = 8;
    localparam int DEF_ROI_Y0      = 240;
    localparam int DEF_ROI_Y1      = 479;
    localparam int DEF_MIN_STRIPES = 3;
    localparam int DEF_MAX_STRIPES = 12;
    localparam int DEF_ROW_QUORUM  = 32;
    localparam int DEF_ON_FRAMES   = 3;
    localparam int DEF_OFF_FRAMES  = 5;

    localparam int STRIPE_W   = 8;   // per-row transition count, saturates at 255
    localparam int ROWS_W     = 16;  // qualifying-row count, saturates at 65535
    localparam int HYST_CNT_W = 8;   // hit/miss frame counters

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMING    = 2'd1,
        ST_DETECTED  = 2'd2,
        ST_RELEASING = 2'd3
    } hyst_state_t;

endpackage

// File: rtl/zebra_frame_detector_row_stripe_counter.sv
// Counts 0->1 transitions of the binarised edge bit along one row and
// qualifies the row on its last pixel against the stripe window.
module row_stripe_counter
    import zebra_pkg::*;
#(
    parameter int MIN_STRIPES = DEF_MIN_STRIPES,
    parameter int MAX_STRIPES = DEF_MAX_STRIPES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pix_valid,
    input  logic                pix_bit,
    input  logic                row_first,
    input  logic                row_last,
    input  logic                in_roi,
    output logic                row_qualifies,
    output logic [STRIPE_W-1:0] row_count
);

    logic                prev_q;
    logic [STRIPE_W-1:0] count_q;
    logic [STRIPE_W-1:0] count_base;
    logic                rise;

    // The bit before x=0 is treated as 0, so a row starting high counts one stripe.
    assign count_base = row_first ? '0 : count_q;
    assign rise       = pix_bit & ~(prev_q & ~row_first);
    assign row_count  = (rise && (count_base != '1)) ? count_base + STRIPE_W'(1) : count_base;

    assign row_qualifies = pix_valid && row_last && in_roi &&
                           (int'(row_count) >= MIN_STRIPES) &&
                           (int'(row_count) <= MAX_STRIPES);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q  <= 1'b0;
            count_q <= '0;
        end else if (pix_valid) begin
            prev_q  <= pix_bit;
            count_q <= row_count;
        end
    end

endmodule

// File: rtl/zebra_frame_detector.sv
// Frame-level zebra-crossing detector: pixel raster tracking, per-frame row
// accumulation, end-of-frame result registers and a hit/miss hysteresis FSM.
module zebra_frame_detector
    import zebra_pkg::*;
#(
    parameter int IMG_WIDTH   = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT  = DEF_IMG_HEIGHT,
    parameter int W           = DEF_W,
    parameter int ROI_Y0      = DEF_ROI_Y0,
    parameter int ROI_Y1      = DEF_ROI_Y1,
    parameter int MIN_STRIPES = DEF_MIN_STRIPES,
    parameter int MAX_STRIPES = DEF_MAX_STRIPES,
    parameter int ROW_QUORUM  = DEF_ROW_QUORUM,
    parameter int ON_FRAMES   = DEF_ON_FRAMES,
    parameter int OFF_FRAMES  = DEF_OFF_FRAMES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                x_valid,
    input  logic [W-1:0]        x_data,
    input  logic                frame_start,
    input  logic [W-1:0]        edge_thresh,
    output logic                detection_valid,
    output logic                frame_hit,
    output logic [STRIPE_W-1:0] stripe_count,
    output logic [ROWS_W-1:0]   confidence,
    output logic                crossing_detected
);

    localparam int X_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int Y_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    logic [X_W-1:0] x_q, cur_x;
    logic [Y_W-1:0] y_q, cur_y;
    logic           fs, row_last, col_first, frame_last, in_roi, pix_bit;

    // frame_start re-anchors the raster to (0,0), silently dropping any partial frame.
    assign fs         = x_valid & frame_start;
    assign cur_x      = fs ? '0 : x_q;
    assign cur_y      = fs ? '0 : y_q;
    assign col_first  = (cur_x == '0);
    assign row_last   = (int'(cur_x) == IMG_WIDTH - 1);
    assign frame_last = x_valid && row_last && (int'(cur_y) == IMG_HEIGHT - 1);
    assign in_roi     = (int'(cur_y) >= ROI_Y0) && (int'(cur_y) <= ROI_Y1);
    assign pix_bit    = (x_data >= edge_thresh);

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else if (x_valid) begin
            if (row_last) begin
                x_q <= '0;
                y_q <= (int'(cur_y) == IMG_HEIGHT - 1) ? '0 : cur_y + Y_W'(1);
            end else begin
                x_q <= cur_x + X_W'(1);
                y_q <= cur_y;
            end
        end
    end

    logic                row_qualifies;
    logic [STRIPE_W-1:0] row_count;

    row_stripe_counter #(
        .MIN_STRIPES (MIN_STRIPES),
        .MAX_STRIPES (MAX_STRIPES)
    ) u_row (
        .clk           (clk),
        .rst           (rst),
        .pix_valid     (x_valid),
        .pix_bit       (pix_bit),
        .row_first     (col_first),
        .row_last      (row_last),
        .in_roi        (in_roi),
        .row_qualifies (row_qualifies),
        .row_count     (row_count)
    );

    logic [ROWS_W-1:0]   rows_q, rows_base, rows_next;
    logic [STRIPE_W-1:0] max_q, max_base, max_next;
    logic                hit_now;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        rows_base = fs ? '0 : rows_q;
        max_base  = fs ? '0 : max_q;
        rows_next = rows_base;
        max_next  = max_base;
        if (row_qualifies) begin
            if (rows_base != '1)
                rows_next = rows_base + ROWS_W'(1);
            if (row_count > max_base)
                max_next = row_count;
        end
    end

    assign hit_now = (int'(rows_next) >= ROW_QUORUM);

    always_ff @(posedge clk) begin
        if (rst) begin
            rows_q          <= '0;
            max_q           <= '0;
            detection_valid <= 1'b0;
            frame_hit       <= 1'b0;
            stripe_count    <= '0;
            confidence      <= '0;
        end else begin
            detection_valid <= frame_last;
            if (x_valid) begin
                rows_q <= frame_last ? '0 : rows_next;
                max_q  <= frame_last ? '0 : max_next;
            end
            if (frame_last) begin
                confidence   <= rows_next;
                stripe_count <= (rows_next == '0) ? '0 : max_next;
                frame_hit    <= hit_now;
            end
        end
    end

    hyst_state_t           state_q, state_d;
    logic [HYST_CNT_W-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    // The FSM steps on the same edge that raises detection_valid, so
    // crossing_detected is already current when the pulse is seen.
    always_comb begin
        state_d    = state_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (frame_last) begin
            case (state_q)
                ST_IDLE: if (hit_now) begin
                    hit_cnt_d = HYST_CNT_W'(1);
                    state_d   = (ON_FRAMES <= 1) ? ST_DETECTED : ST_ARMING;
                end
                ST_ARMING: if (hit_now) begin
                    hit_cnt_d = hit_cnt_q + HYST_CNT_W'(1);
                    if (int'(hit_cnt_d) >= ON_FRAMES)
                        state_d = ST_DETECTED;
                end else begin
                    hit_cnt_d = '0;
                    state_d   = ST_IDLE;
                end
                ST_DETECTED: if (!hit_now) begin
                    miss_cnt_d = HYST_CNT_W'(1);
                    state_d    = (OFF_FRAMES <= 1) ? ST_IDLE : ST_RELEASING;
                end
                ST_RELEASING: if (hit_now) begin
                    miss_cnt_d = '0;
                    state_d    = ST_DETECTED;
                end else begin
                    miss_cnt_d = miss_cnt_q + HYST_CNT_W'(1);
                    if (int'(miss_cnt_d) >= OFF_FRAMES)
                        state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= ST_IDLE;
            hit_cnt_q         <= '0;
            miss_cnt_q        <= '0;
            crossing_detected <= 1'b0;
        end else begin
            state_q           <= state_d;
            hit_cnt_q         <= hit_cnt_d;
            miss_cnt_q        <= miss_cnt_d;
            crossing_detected <= (state_d == ST_DETECTED) || (state_d == ST_RELEASING);
        end
    end

endmodule
